// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/done handshake, feeding the ZHI/ZLO register pair.
//   Single-cycle ops (ADD, SUB, AND, OR, shifts, rotates, NEG, NOT) complete on the accept edge.
//   MUL is an iterative radix-2 Booth multiply (WIDTH steps).
//   DIV is a restoring signed divide (WIDTH steps plus a sign-fix cycle).
// Optional feature: define SEQ_ALU_FLAGS_EN to add flag_z/flag_n/flag_c/flag_v outputs.
// Ports:
//   clock     rising-edge clock
//   clear     asynchronous active-high reset
//   start     request, sampled only while busy is low
//   op        4-bit opcode
//   Ra, Rb    operands (Rb[SH_W-1:0] is the shift/rotate amount)
//   busy      MUL/DIV in progress
//   done      one-cycle completion pulse
//   div_zero  sticky: last DIV had a zero divisor
//   ZHI, ZLO  high/low result
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH),
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
`endif
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpShr  = 4'd4;
    localparam logic [3:0] OpShra = 4'd5;
    localparam logic [3:0] OpShl  = 4'd6;
    localparam logic [3:0] OpRor  = 4'd7;
    localparam logic [3:0] OpRol  = 4'd8;
    localparam logic [3:0] OpMul  = 4'd9;
    localparam logic [3:0] OpDiv  = 4'd10;
    localparam logic [3:0] OpNeg  = 4'd11;
    localparam logic [3:0] OpNot  = 4'd12;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDivFix} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend-then-quotient
    logic             qm1_q, qm1_d;     // Booth q(-1) bit
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
    logic             done_q, done_d, dz_q, dz_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] add_res, sub_res, simple_lo, abs_a, abs_b;
    logic [SH_W-1:0]  amt;
    logic [SH_W:0]    inv_amt;

`ifdef SEQ_ALU_FLAGS_EN
    logic [WIDTH:0] add_ext, sub_ext;
    assign add_ext = {1'b0, Ra} + {1'b0, Rb};
    assign sub_ext = {1'b0, Ra} + {1'b0, ~Rb} + {{WIDTH{1'b0}}, 1'b1};
    assign add_res = add_ext[WIDTH-1:0];
    assign sub_res = sub_ext[WIDTH-1:0];
`else
    assign add_res = Ra + Rb;
    assign sub_res = Ra - Rb;
`endif

    assign amt     = Rb[SH_W-1:0];
    // Shifting by WIDTH yields zero, so amount 0 rotates to Ra unchanged.
    assign inv_amt = (SH_W + 1)'(WIDTH) - {1'b0, amt};
    assign abs_a   = Ra[WIDTH-1] ? -Ra : Ra;
    assign abs_b   = Rb[WIDTH-1] ? -Rb : Rb;

    always_comb begin
        simple_lo = '0;
        case (op)
            OpAdd:   simple_lo = add_res;
            OpSub:   simple_lo = sub_res;
            OpAnd:   simple_lo = Ra & Rb;
            OpOr:    simple_lo = Ra | Rb;
            OpShr:   simple_lo = Ra >> amt;
            OpShra:  simple_lo = $signed(Ra) >>> amt;
            OpShl:   simple_lo = Ra << amt;
            OpRor:   simple_lo = (Ra >> amt) | (Ra << inv_amt);
            OpRol:   simple_lo = (Ra << amt) | (Ra >> inv_amt);
            OpNeg:   simple_lo = -Rb;
            OpNot:   simple_lo = ~Rb;
            default: simple_lo = '0;
        endcase
    end

    // Booth step: add/sub multiplicand per {q0, q-1}, then arithmetic shift right of {acc, mq, q-1}.
    // The accumulator is one bit wider so that subtracting the most negative multiplicand cannot wrap.
    logic [WIDTH:0]   mcand_ext, booth_sum, booth_acc;
    logic [WIDTH-1:0] booth_mq;

    assign mcand_ext = {opnd_q[WIDTH-1], opnd_q};

    always_comb begin
        booth_sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
    end

    assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_mq  = {booth_sum[0], mq_q[WIDTH-1:1]};

    // Restoring divide step on magnitudes: shift in next dividend bit, keep trial if non-negative.
    logic [WIDTH:0] div_shift, div_trial;
    logic           div_fits;

    assign div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_fits  = ~div_trial[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        opnd_d  = opnd_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dz_d  = 1'b0;
                    cnt_d = '0;
                    if (op == OpMul) begin
                        acc_d   = '0;
                        mq_d    = Rb;
                        qm1_d   = 1'b0;
                        opnd_d  = Ra;
                        state_d = StMul;
                    end else if (op == OpDiv) begin
                        acc_d   = '0;
                        mq_d    = abs_a;
                        opnd_d  = abs_b;
                        neg_a_d = Ra[WIDTH-1];
                        neg_b_d = Rb[WIDTH-1];
                        if (Rb == '0) begin
                            dz_d    = 1'b1;
                            state_d = StDivFix;
                        end else begin
                            state_d = StDiv;
                        end
                    end else begin
                        zhi_d  = '0;
                        zlo_d  = simple_lo;
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d = booth_acc;
                mq_d  = booth_mq;
                qm1_d = mq_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    zhi_d   = booth_acc[WIDTH-1:0];
                    zlo_d   = booth_mq;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiv: begin
                acc_d = div_fits ? div_trial : div_shift;
                mq_d  = {mq_q[WIDTH-2:0], div_fits};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDivFix;
                end
            end
            StDivFix: begin
                if (dz_q) begin
                    // mq still holds |Ra|; restore the original dividend.
                    zhi_d = neg_a_q ? -mq_q : mq_q;
                    zlo_d = '1;
                end else begin
                    zlo_d = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
                    zhi_d = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            opnd_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            opnd_q  <= opnd_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign ZHI      = zhi_q;
    assign ZLO      = zlo_q;

`ifdef SEQ_ALU_FLAGS_EN
    logic fz_q, fn_q, fc_q, fv_q, fc_d, fv_d;

    always_comb begin
        fc_d = 1'b0;
        fv_d = 1'b0;
        if (state_q == StIdle && start) begin
            case (op)
                OpAdd: begin
                    fc_d = add_ext[WIDTH];
                    fv_d = (Ra[WIDTH-1] == Rb[WIDTH-1]) && (add_ext[WIDTH-1] != Ra[WIDTH-1]);
                end
                OpSub: begin
                    fc_d = sub_ext[WIDTH];
                    fv_d = (Ra[WIDTH-1] != Rb[WIDTH-1]) && (sub_ext[WIDTH-1] != Ra[WIDTH-1]);
                end
                OpNeg:   fv_d = (Rb == {1'b1, {(WIDTH - 1){1'b0}}});
                default: fv_d = 1'b0;
            endcase
        end else if (state_q == StMul) begin
            // Product fits in WIDTH bits only if the high half is the sign extension of the low.
            fv_d = (booth_acc[WIDTH-1:0] != {WIDTH{booth_mq[WIDTH-1]}});
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            fz_q <= 1'b0;
            fn_q <= 1'b0;
            fc_q <= 1'b0;
            fv_q <= 1'b0;
        end else if (done_d) begin
            fz_q <= (zlo_d == '0);
            fn_q <= zlo_d[WIDTH-1];
            fc_q <= fc_d;
            fv_q <= fv_d;
        end
    end

    assign flag_z = fz_q;
    assign flag_n = fn_q;
    assign flag_c = fc_q;
    assign flag_v = fv_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): behavioural reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_seq_alu;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op    = 4'd0;
    logic [W-1:0] Ra    = '0;
    logic [W-1:0] Rb    = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] ZHI, ZLO;
`ifdef SEQ_ALU_FLAGS_EN
    logic flag_z, flag_n, flag_c, flag_v;
`endif

    bit clk_run = 1'b0;
    int total   = 0;
    int bad     = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .Ra       (Ra),
        .Rb       (Rb),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .ZHI      (ZHI),
        .ZLO      (ZLO)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .flag_v   (flag_v)
`endif
    );

    initial forever #5 if (clk_run) clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_z(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, p;
        logic [31:0] hi, lo;
        int          sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[4:0]);
        hi = '0;
        lo = '0;
        case (o)
            4'd0: lo = a + b;
            4'd1: lo = a - b;
            4'd2: lo = a & b;
            4'd3: lo = a | b;
            4'd4: lo = a >> sh;
            4'd5: begin p = sa >>> sh; lo = p[31:0]; end
            4'd6: lo = a << sh;
            4'd7: begin lo = a; repeat (sh) lo = {lo[0], lo[31:1]}; end
            4'd8: begin lo = a; repeat (sh) lo = {lo[30:0], lo[31]}; end
            4'd9: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            4'd10: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else begin
                    p  = sa / sb;
                    lo = p[31:0];
                    p  = sa % sb;
                    hi = p[31:0];
                end
            end
            4'd11: lo = -b;
            4'd12: lo = ~b;
            default: begin hi = '0; lo = '0; end
        endcase
        return {hi, lo};
    endfunction

    function automatic logic out_of_range(input longint s);
        int t;
        t = int'(s[31:0]);
        return s != longint'(t);
    endfunction

    function automatic logic [3:0] model_f(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] r;
        longint      sa, sb;
        logic        c, v;
        r  = model_z(o, a, b);
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            4'd0: begin c = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF; v = out_of_range(sa + sb); end
            4'd1: begin c = (a >= b); v = out_of_range(sa - sb); end
            4'd9: v = out_of_range(sa * sb);
            4'd11: v = out_of_range(-sb);
            default: v = 1'b0;
        endcase
        return {r[31:0] == 32'h0, r[31], c, v};
    endfunction

    // Cycles spent busy after the accept edge.
    function automatic int model_busy(input logic [3:0] o, input logic [31:0] b);
        if (o == 4'd9) return W;
        if (o == 4'd10) return (b == 0) ? 1 : W + 1;
        return 0;
    endfunction

    int          m_rem  = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_z    = '0;
    logic [3:0]  m_pf   = '0;
    logic [3:0]  m_f    = '0;
    logic        m_done = 1'b0;
    logic        m_dz   = 1'b0;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_rem  <= 0;
            m_z    <= '0;
            m_f    <= '0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_z    <= m_pend;
                    m_f    <= m_pf;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_dz <= (op == 4'd10) && (Rb == 0);
                if (model_busy(op, Rb) == 0) begin
                    m_z    <= model_z(op, Ra, Rb);
                    m_f    <= model_f(op, Ra, Rb);
                    m_done <= 1'b1;
                end else begin
                    m_rem  <= model_busy(op, Rb);
                    m_pend <= model_z(op, Ra, Rb);
                    m_pf   <= model_f(op, Ra, Rb);
                end
            end
        end
    end

    // Compare process: outputs are registered, so sample on the falling edge.
    always @(negedge clock) begin
        chk("busy", 64'(busy), 64'(m_rem != 0));
        chk("done", 64'(done), 64'(m_done));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("ZHI", 64'(ZHI), 64'(m_z[63:32]));
        chk("ZLO", 64'(ZLO), 64'(m_z[31:0]));
`ifdef SEQ_ALU_FLAGS_EN
        chk("flags", 64'({flag_z, flag_n, flag_c, flag_v}), 64'(m_f));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        Ra    = a;
        Rb    = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
        chk({name, "_dz"}, 64'(div_zero), 64'd0);
        chk({name, "_zhi"}, 64'(ZHI), 64'd0);
        chk({name, "_zlo"}, 64'(ZLO), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] burst_ops[$];

    initial begin
        int c;
        int nd;
        // Reset with the clock stopped.
        #3 clear = 1'b1;
        #1 chk_all_zero("reset");
        #2 clear = 1'b0;
        clk_run = 1'b1;
        @(negedge clock);

        issue(4'd0, 32'd7, 32'd5);
        chk("add_done", 64'(done), 64'd1);
        chk("add_lo", 64'(ZLO), 64'd12);
        chk("add_hi", 64'(ZHI), 64'd0);
        issue(4'd1, 32'd5, 32'd7);
        chk("sub_lo", 64'(ZLO), 64'hFFFF_FFFE);
        issue(4'd7, 32'h8000_0001, 32'h21);
        chk("ror_lo", 64'(ZLO), 64'hC000_0000);
        issue(4'd5, 32'h8000_0000, 32'd4);
        chk("shra_lo", 64'(ZLO), 64'hF800_0000);

        // MUL with an ignored start while busy.
        issue(4'd9, -32'sd3, 32'd7);
        repeat (3) @(negedge clock);
        issue(4'd0, 32'd1, 32'd1);
        wait_done(40, c);
        chk("mul_latency", 64'(c + 4), 64'd32);
        chk("mul_hi", 64'(ZHI), 64'hFFFF_FFFF);
        chk("mul_lo", 64'(ZLO), 64'hFFFF_FFEB);

        // New start in the done cycle.
        issue(4'd10, -32'sd17, 32'd5);
        wait_done(40, c);
        chk("div_latency", 64'(c), 64'd33);
        chk("div_lo", 64'(ZLO), 64'hFFFF_FFFD);
        chk("div_hi", 64'(ZHI), 64'hFFFF_FFFE);

        issue(4'd10, 32'h1234_5678, 32'd0);
        chk("div0_flag", 64'(div_zero), 64'd1);
        wait_done(5, c);
        chk("div0_latency", 64'(c), 64'd1);
        chk("div0_lo", 64'(ZLO), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(ZHI), 64'h1234_5678);

        issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, c);
        chk("divmin_lo", 64'(ZLO), 64'h8000_0000);
        chk("divmin_hi", 64'(ZHI), 64'd0);

        // Clear with the clock stopped while outputs are non-zero.
        clk_run = 1'b0;
        #20 clear = 1'b1;
        #1 chk_all_zero("clear_stopped");
        clear = 1'b0;
        #1 clk_run = 1'b1;
        @(negedge clock);

        // Abort a MUL at cycle 10.
        issue(4'd9, 32'd1234, 32'd5678);
        repeat (9) @(negedge clock);
        #2 clear = 1'b1;
        #1 chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        #1 clear = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        issue(4'd0, 32'd100, 32'd23);
        chk("post_abort_done", 64'(done), 64'd1);
        chk("post_abort_lo", 64'(ZLO), 64'd123);

        // Boundary vectors, checked by the model.
        vecs.push_back('{4'd9, 32'h8000_0000, 32'h8000_0000});
        vecs.push_back('{4'd9, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{4'd9, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
        vecs.push_back('{4'd9, 32'd12345, -32'sd6789});
        vecs.push_back('{4'd9, 32'd0, 32'h8000_0000});
        vecs.push_back('{4'd10, 32'd100, -32'sd7});
        vecs.push_back('{4'd10, -32'sd100, -32'sd7});
        vecs.push_back('{4'd10, 32'd7, 32'd100});
        vecs.push_back('{4'd10, 32'h8000_0000, 32'd1});
        vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{4'd11, 32'd0, 32'h8000_0000});
        vecs.push_back('{4'd0, 32'h7FFF_FFFF, 32'd1});
        vecs.push_back('{4'd0, 32'hFFFF_FFFF, 32'd1});
        vecs.push_back('{4'd1, 32'd0, 32'd1});
        vecs.push_back('{4'd1, 32'h8000_0000, 32'd1});
        vecs.push_back('{4'd6, 32'hDEAD_BEEF, 32'h20});
        vecs.push_back('{4'd4, 32'hDEAD_BEEF, 32'd31});
        vecs.push_back('{4'd8, 32'hDEAD_BEEF, 32'h23});
        vecs.push_back('{4'd13, 32'hDEAD_BEEF, 32'd5});
        vecs.push_back('{4'd15, 32'hDEAD_BEEF, 32'd5});
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b);
            wait_done(40, c);
        end

        // Back-to-back single-cycle ops.
        burst_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                      4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        foreach (burst_ops[i]) begin
            issue(burst_ops[i], 32'(i + 1) * 32'h9E37_79B9, 32'(i * 7) ^ 32'hA5A5_0F03);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
